// File: rtl/crypto_stream_adapter.sv
// Byte-stream adapter for the 128-bit crypto controller: packs 16 bytes, launches one encryption, drains 16 result bytes.
// Optional CRYPTO_ADAPTER_PAD_EN: in_last before byte 15 pads the block (value 15-k) and launches early.
module crypto_stream_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [1:0]   cfg_mode,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic [1:0]   crypto_mode,
  output logic         encrypt_start,
  input  logic [127:0] ciphertext,
  input  logic         encrypt_done,
  output logic         timeout_err,
  output logic [15:0]  blocks_done
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  logic [1:0]   state;
  logic [3:0]   byte_idx;
  logic [15:0]  wait_cnt;
  logic [15:0]  wait_next;
  logic [127:0] out_shift;
  logic         in_fire;
  logic         out_fire;
  logic         timeout_hit;
  logic         pad_now;

  assign in_ready      = (state == FILL);
  assign out_valid     = (state == DRAIN);
  assign encrypt_start = (state == START);
  assign out_data      = out_shift[127:120];
  assign in_fire       = in_valid & in_ready;
  assign out_fire      = out_valid & out_ready;
  assign wait_next     = wait_cnt + 16'd1;
  // Abort once the count of cycles spent in WAIT reaches the limit.
  assign timeout_hit   = (wait_next == TIMEOUT_VAL);

`ifdef CRYPTO_ADAPTER_PAD_EN
  assign pad_now = in_last && (byte_idx != 4'd15);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign pad_now        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      byte_idx    <= 4'd0;
      wait_cnt    <= 16'd0;
      out_shift   <= 128'd0;
      plaintext   <= 128'd0;
      crypto_mode <= 2'd0;
      timeout_err <= 1'b0;
      blocks_done <= 16'd0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            plaintext[8*(15-int'(byte_idx)) +: 8] <= in_data;
            if (byte_idx == 4'd0) crypto_mode <= cfg_mode;
`ifdef CRYPTO_ADAPTER_PAD_EN
            if (pad_now) begin
              for (int j = 0; j < 16; j++) begin
                if (j > int'(byte_idx)) plaintext[8*(15-j) +: 8] <= 8'd15 - {4'd0, byte_idx};
              end
            end
`endif
            if (byte_idx == 4'd15 || pad_now) begin
              state    <= START;
              byte_idx <= 4'd0;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        START: begin
          wait_cnt <= 16'd0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_next;
          // A done arriving in the timeout cycle still wins.
          if (encrypt_done) begin
            out_shift <= ciphertext;
            byte_idx  <= 4'd0;
            state     <= DRAIN;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            byte_idx    <= 4'd0;
            state       <= FILL;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            out_shift <= {out_shift[119:0], 8'h00};
            if (byte_idx == 4'd15) begin
              byte_idx    <= 4'd0;
              blocks_done <= blocks_done + 16'd1;
              state       <= FILL;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_stream_adapter.sv
// Randomized self-checking bench for crypto_stream_adapter; the bench plays the crypto controller.
module tb_crypto_stream_adapter;

  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [1:0]   cfg_mode;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic [1:0]   crypto_mode;
  logic         encrypt_start;
  logic [127:0] ciphertext;
  logic         encrypt_done;
  logic         timeout_err;
  logic [15:0]  blocks_done;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] byte_q[$];
  logic [1:0] exp_mode;
  logic       exp_terr;
  int         exp_blocks;

  crypto_stream_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .cfg_mode(cfg_mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .plaintext(plaintext), .crypto_mode(crypto_mode), .encrypt_start(encrypt_start),
    .ciphertext(ciphertext), .encrypt_done(encrypt_done),
    .timeout_err(timeout_err), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected block: bytes in arrival order, most significant first, padded when the message ended early.
  function automatic logic [127:0] expPlain();
    logic [127:0] acc = '0;
    int n = byte_q.size();
    foreach (byte_q[i]) acc = (acc << 8) | 128'(byte_q[i]);
`ifdef CRYPTO_ADAPTER_PAD_EN
    for (int i = n; i < 16; i++) acc = (acc << 8) | 128'(16 - n);
`endif
    return acc;
  endfunction

  // pattern: 0 random bytes, 1 counting bytes 00.., 2 constant AA
  task automatic feedBytes(input int n, input int last_at, input int pattern, input bit spurious);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = (pattern == 1) ? 8'(byte_q.size()) : (pattern == 2) ? 8'hAA : 8'($urandom);
      in_last  = (i == last_at);
      cfg_mode = (pattern == 1) ? 2'd2 : 2'($urandom);
      if (byte_q.size() == 0) exp_mode = cfg_mode;
      encrypt_done = spurious ? 1'($urandom) : 1'b0;
      checkOutput("fill_in_ready", in_ready, 1);
      checkOutput("fill_no_start", encrypt_start, 0);
      byte_q.push_back(in_data);
      step();
    end
    in_valid     = 1'b0;
    in_last      = 1'b0;
    encrypt_done = 1'b0;
  endtask

  task automatic checkStart();
    checkOutput("start_pulse", encrypt_start, 1);
    checkOutput("start_in_ready", in_ready, 0);
    checkOutput("plaintext", plaintext, expPlain());
    checkOutput("crypto_mode", crypto_mode, exp_mode);
  endtask

  // Called in the START cycle. delay > TMO means the controller never answers.
  task automatic applyStimulus(input int delay, input logic [127:0] ct, input bit toggle, input bit spurious);
    logic [127:0] exp_pt = expPlain();
    int last = (delay > TMO) ? TMO : delay;
    int idx = 0;
    int cyc = 0;
    for (int c = 1; c <= last; c++) begin
      step();
      in_valid     = 1'($urandom);
      in_data      = 8'($urandom);
      encrypt_done = (c == delay);
      ciphertext   = (c == delay) ? ct : 128'({$urandom, $urandom, $urandom, $urandom});
      checkOutput("wait_no_start", encrypt_start, 0);
      checkOutput("wait_in_ready", in_ready, 0);
      checkOutput("wait_out_valid", out_valid, 0);
      checkOutput("wait_terr", timeout_err, exp_terr);
    end
    step();
    in_valid     = 1'b0;
    encrypt_done = 1'b0;
    if (delay > TMO) begin
      exp_terr = 1'b1;
      checkOutput("timeout_err", timeout_err, 1);
      checkOutput("timeout_in_ready", in_ready, 1);
      checkOutput("timeout_out_valid", out_valid, 0);
      byte_q.delete();
      return;
    end
    checkOutput("drain_out_valid", out_valid, 1);
    checkOutput("drain_terr", timeout_err, exp_terr);
    checkOutput("plaintext_stable", plaintext, exp_pt);
    while (idx < 16 && cyc < 200) begin
      out_ready    = toggle ? 1'(cyc % 2) : 1'($urandom);
      encrypt_done = spurious ? 1'($urandom) : 1'b0;
      checkOutput("drain_valid", out_valid, 1);
      if (out_ready) begin
        checkOutput($sformatf("out_byte%0d", idx), out_data, 8'(ct >> (8 * (15 - idx))));
        idx++;
      end
      step();
      cyc++;
    end
    if (idx < 16) checkOutput("drain_bound", 0, 1);
    out_ready    = 1'b0;
    encrypt_done = 1'b0;
    exp_blocks++;
    checkOutput("blocks_done", blocks_done, 16'(exp_blocks));
    checkOutput("post_out_valid", out_valid, 0);
    checkOutput("post_in_ready", in_ready, 1);
    byte_q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_plaintext"}, plaintext, 0);
    checkOutput({tag, "_mode"}, crypto_mode, 0);
    checkOutput({tag, "_start"}, encrypt_start, 0);
    checkOutput({tag, "_terr"}, timeout_err, 0);
    checkOutput({tag, "_blocks"}, blocks_done, 0);
  endtask

  function automatic logic [127:0] randCt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 0; in_last = 0; cfg_mode = '0;
    out_ready = 0; ciphertext = '0; encrypt_done = 0;
    exp_terr = 0; exp_blocks = 0; exp_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    step();

    $display("[TB] counting block, done after 70 cycles, toggled out_ready");
    feedBytes(16, -1, 1, 0);
    checkStart();
    applyStimulus(70, 128'hFFEEDDCCBBAA99887766554433221100, 1, 0);

    $display("[TB] random blocks with spurious done");
    for (int b = 0; b < 6; b++) begin
      feedBytes(16, -1, 0, 1);
      checkStart();
      applyStimulus(int'($urandom_range(1, TMO - 1)), randCt(), 0, 1);
    end

    $display("[TB] done coincident with timeout");
    feedBytes(16, -1, 0, 0);
    checkStart();
    applyStimulus(TMO, randCt(), 0, 0);

    $display("[TB] in_last on fifth byte");
    feedBytes(5, 4, 2, 0);
`ifdef CRYPTO_ADAPTER_PAD_EN
    checkStart();
`else
    for (int i = 0; i < 5; i++) begin
      checkOutput("nopad_no_start", encrypt_start, 0);
      checkOutput("nopad_in_ready", in_ready, 1);
      step();
    end
    feedBytes(11, -1, 0, 0);
    checkStart();
`endif
    applyStimulus(int'($urandom_range(1, 20)), randCt(), 0, 0);

    $display("[TB] timeout without done");
    feedBytes(16, -1, 0, 0);
    checkStart();
    applyStimulus(TMO + 1, '0, 0, 0);
    checkOutput("terr_sticky", timeout_err, 1);

    $display("[TB] reset during wait");
    feedBytes(16, -1, 0, 0);
    checkStart();
    repeat (3) step();
    #2 rst = 1'b1;
    #1 checkResetValues("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_terr = 0; exp_blocks = 0;
    byte_q.delete();
    feedBytes(16, -1, 0, 0);
    checkStart();
    applyStimulus(int'($urandom_range(1, 30)), randCt(), 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
